// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared frame-buffer constants, write-FSM states and FIFO entry.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 16;
    localparam int FB_PIXELS = 76800;

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        STREAM   = 1'b1
    } fb_state_t;

    typedef struct packed {
        logic                 sof;
        logic [FB_DATA_W-1:0] data;
    } fb_entry_t;

endpackage
`default_nettype wire

// File: rtl/fb_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fb_wr_fifo
// Description : Synchronous FIFO buffering camera pixels with their sof flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = $bits(fb_entry_t)
) (
    input  logic                     clk25,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + c_cnt_w'(w_push_ok) - c_cnt_w'(w_pop_ok);
        end
    end

    always_ff @(posedge clk25) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign full     = (r_count == c_cnt_w'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/fb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_port_arbiter
// Description : Shares one frame-buffer BRAM port between VGA reads (priority)
//               and FIFO-buffered camera writes. FB_PORT_STATS_EN adds
//               stall_cnt / fifo_hwm statistics outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W       = FB_ADDR_W,
    parameter int DATA_W       = FB_DATA_W,
    parameter int FIFO_DEPTH   = 16,
    parameter int FRAME_PIXELS = FB_PIXELS
) (
    input  logic                          clk25,
    input  logic                          rst_n,
`ifdef FB_PORT_STATS_EN
    output logic [15:0]                   stall_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_hwm,
`endif
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    input  logic                          wr_valid,
    input  logic                          wr_sof,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    output logic                          frame_done,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int                c_cnt_w     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(FRAME_PIXELS - 1);

    fb_state_t          r_state;
    fb_state_t          w_state_next;
    fb_entry_t          w_push_entry;
    fb_entry_t          w_pop_entry;
    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [c_cnt_w-1:0] w_count;
    logic [c_cnt_w-1:0] w_count_next;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic [ADDR_W-1:0]  r_waddr;

    logic               r_mem_en;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_rd_valid;
    logic               r_wr_ready;
    logic               r_frame_done;

    assign w_accept          = wr_valid && r_wr_ready;
    assign w_push_entry.sof  = wr_sof;
    assign w_push_entry.data = wr_data;
    assign w_pop             = !rd_req && !w_empty;
    assign w_count_next      = w_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    assign w_wr_addr         = w_pop_entry.sof ? '0 : r_waddr;

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk25     (clk25),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .pop_data  (w_pop_entry),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) r_state <= WAIT_SOF;
        else        r_state <= w_state_next;
    end

    // Beats ahead of the first sof are handshaken but dropped.
    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        case (r_state)
            WAIT_SOF: begin
                if (w_accept && wr_sof) begin
                    w_push       = !w_full;
                    w_state_next = STREAM;
                end
            end
            STREAM:   w_push = w_accept && !w_full;
            default:  w_state_next = WAIT_SOF;
        endcase
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_wr_ready   <= 1'b0;
            r_frame_done <= 1'b0;
            r_waddr      <= '0;
        end else begin
            // Look ahead at next occupancy so wr_ready never admits a beat into a full FIFO.
            r_wr_ready   <= (w_count_next != c_cnt_w'(FIFO_DEPTH));
            r_frame_done <= 1'b0;
            r_rd_valid   <= r_mem_en && !r_mem_we;
            if (r_mem_en && !r_mem_we) r_rd_data <= mem_rdata;

            if (rd_req) begin
                r_mem_en   <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= rd_addr;
            end else if (!w_empty) begin
                r_mem_en     <= 1'b1;
                r_mem_we     <= 1'b1;
                r_mem_addr   <= w_wr_addr;
                r_mem_wdata  <= w_pop_entry.data;
                r_waddr      <= (w_wr_addr == c_last_addr) ? '0 : w_wr_addr + 1'b1;
                r_frame_done <= (w_wr_addr == c_last_addr);
            end else begin
                r_mem_en <= 1'b0;
                r_mem_we <= 1'b0;
            end
        end
    end

    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign wr_ready   = r_wr_ready;
    assign frame_done = r_frame_done;

`ifdef FB_PORT_STATS_EN
    logic [15:0]        r_stall_cnt;
    logic [c_cnt_w-1:0] r_fifo_hwm;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_fifo_hwm  <= '0;
        end else if (w_accept && wr_sof) begin
            r_stall_cnt <= '0;
            r_fifo_hwm  <= '0;
        end else begin
            if (wr_valid && !r_wr_ready && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_count > r_fifo_hwm)
                r_fifo_hwm <= w_count;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign fifo_hwm  = r_fifo_hwm;
`else
    // Statistics outputs are not built in this configuration.
`endif

endmodule
`default_nettype wire
